// File: rtl/can_pkg.sv
// Shared definitions for the CAN controller blocks.
//   CAN_CRC_POLY   CRC15 generator, bit 15 is the implicit x^15 term.
//   CAN_*_W        field widths of a standard (11-bit ID) data frame.
//   rx_error_code_e  error classes reported by can_receiver.
//   can_state_e      FSM states of can_receiver.
//   dlc_to_bytes / dlc_to_keep  DLC decoding, DLC 9..15 means 8 bytes.
package can_pkg;

    localparam logic [15:0] CAN_CRC_POLY = 16'hC599;
    localparam int unsigned CAN_ID_W     = 11;
    localparam int unsigned CAN_DLC_W    = 4;
    localparam int unsigned CAN_CRC_W    = 15;
    localparam int unsigned CAN_DATA_W   = 64;
    localparam int unsigned CAN_EOF_BITS = 7;

    typedef enum logic [1:0] {
        ErrStuff    = 2'd0,
        ErrCrc      = 2'd1,
        ErrForm     = 2'd2,
        ErrOverflow = 2'd3
    } rx_error_code_e;

    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StAck,
        StEof,
        StError
    } can_state_e;

    function automatic logic [3:0] dlc_to_bytes(input logic [CAN_DLC_W-1:0] dlc);
        return (dlc > 4'd8) ? 4'd8 : dlc;
    endfunction

    function automatic logic [7:0] dlc_to_keep(input logic [CAN_DLC_W-1:0] dlc);
        logic [7:0] keep;
        keep = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(dlc_to_bytes(dlc))) begin
                keep[i] = 1'b1;
            end
        end
        return keep;
    endfunction

endpackage

// File: rtl/can_crc15.sv
// Serial CAN CRC15 (poly 0x4599, init 0), one bit per enabled clock.
//   clk, rst_n   clock and asynchronous active-low reset
//   clear        synchronous clear to 0, wins over enable
//   enable       shift bit_in into the CRC this clock
//   bit_in       serial data bit
//   crc          current CRC register
module can_crc15
    import can_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 enable,
    input  logic                 bit_in,
    output logic [CAN_CRC_W-1:0] crc
);

    logic [CAN_CRC_W-1:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = '0;
        end else if (enable) begin
            crc_d = {crc_q[CAN_CRC_W-2:0], 1'b0};
            if (bit_in ^ crc_q[CAN_CRC_W-1]) begin
                crc_d = crc_d ^ CAN_CRC_POLY[CAN_CRC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/can_receiver.sv
// CAN 2.0A receiver: destuffs, checks stuff/CRC/form rules, drives the ACK slot and
// delivers good standard data frames on an AXI4-Stream master with a single-entry register.
//   clk, rst_n                 clock and asynchronous active-low reset
//   rxd_synced                 synchronised RX line (0 = dominant)
//   sync_point, sampling_point bit-timing strobes
//   can_sending                local sender active, suppresses our ACK
//   txd_ack                    0 = drive dominant for the ACK slot
//   can_receiving              frame in progress (SOF..EOF)
//   rx_error, rx_error_code    1-clk error pulse and its class
//   stm_recv_data_out_*        received frame: payload, ID, byte keep, valid/ready
module can_receiver
    import can_pkg::*;
#(
    parameter int unsigned EOF_IDLE_BITS = 11,
    parameter bit          ACK_ENABLE    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rxd_synced,
    input  logic                  sync_point,
    input  logic                  sampling_point,
    input  logic                  can_sending,
    output logic                  txd_ack,
    output logic                  can_receiving,
    output logic                  rx_error,
    output logic [1:0]            rx_error_code,
    output logic [CAN_DATA_W-1:0] stm_recv_data_out_tdata,
    output logic [CAN_ID_W-1:0]   stm_recv_data_out_tid,
    output logic [7:0]            stm_recv_data_out_tkeep,
    output logic                  stm_recv_data_out_tvalid,
    input  logic                  stm_recv_data_out_tready
);

    localparam int unsigned IdleW = $clog2(EOF_IDLE_BITS + 1);

    can_state_e            state_q, state_d;
    logic [6:0]            bit_cnt_q, bit_cnt_d;     // destuffed bit index, SOF = 0
    logic [2:0]            run_cnt_q, run_cnt_d;
    logic                  last_bit_q, last_bit_d;
    logic [2:0]            sub_cnt_q, sub_cnt_d;     // position inside ACK / EOF
    logic [IdleW-1:0]      idle_cnt_q, idle_cnt_d;
    logic [CAN_ID_W-1:0]   id_q, id_d;
    logic                  rtr_q, rtr_d;
    logic                  ide_q, ide_d;
    logic [CAN_DLC_W-1:0]  dlc_q, dlc_d;
    logic [CAN_DATA_W-1:0] data_q, data_d;
    logic [CAN_CRC_W-1:0]  crc_rx_q, crc_rx_d;
    logic                  crc_err_q, crc_err_d;
    logic                  ack_pending_q, ack_pending_d;
    logic                  txd_ack_q, txd_ack_d;
    logic                  load_q, load_d;
    logic                  rx_error_q, rx_error_d;
    rx_error_code_e        rx_error_code_q, rx_error_code_d;
    logic                  can_receiving_q, can_receiving_d;
    logic [CAN_DATA_W-1:0] tdata_q, tdata_d;
    logic [CAN_ID_W-1:0]   tid_q, tid_d;
    logic [7:0]            tkeep_q, tkeep_d;
    logic                  tvalid_q, tvalid_d;

    logic                  crc_clear, crc_en;
    logic [CAN_CRC_W-1:0]  crc_val;
    logic                  err_set, ovf;
    rx_error_code_e        err_code;
    logic [3:0]            nbytes;
    logic [6:0]            crc_start, crc_delim;
    logic [5:0]            data_idx;
    logic                  rx;

    can_crc15 u_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (crc_clear),
        .enable (crc_en),
        .bit_in (rx),
        .crc    (crc_val)
    );

    assign rx        = rxd_synced;
    assign nbytes    = rtr_q ? 4'd0 : dlc_to_bytes(dlc_q);
    assign crc_start = 7'd19 + {nbytes, 3'b000};
    assign crc_delim = crc_start + 7'd15;
    assign data_idx  = 6'(bit_cnt_q - 7'd19);

    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        run_cnt_d       = run_cnt_q;
        last_bit_d      = last_bit_q;
        sub_cnt_d       = sub_cnt_q;
        idle_cnt_d      = idle_cnt_q;
        id_d            = id_q;
        rtr_d           = rtr_q;
        ide_d           = ide_q;
        dlc_d           = dlc_q;
        data_d          = data_q;
        crc_rx_d        = crc_rx_q;
        crc_err_d       = crc_err_q;
        ack_pending_d   = ack_pending_q;
        txd_ack_d       = txd_ack_q;
        load_d          = 1'b0;
        crc_clear       = 1'b0;
        crc_en          = 1'b0;
        err_set         = 1'b0;
        err_code        = ErrStuff;
        ovf             = 1'b0;
        tdata_d         = tdata_q;
        tid_d           = tid_q;
        tkeep_d         = tkeep_q;
        tvalid_d        = tvalid_q;

        // The ACK request made at the CRC delimiter takes effect for exactly one bit time.
        if (sync_point) begin
            txd_ack_d     = ~ack_pending_q;
            ack_pending_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                crc_clear = 1'b1;
                if (sampling_point && !rx) begin
                    // SOF is fed into the (zero) CRC for completeness.
                    crc_clear  = 1'b0;
                    crc_en     = 1'b1;
                    state_d    = StRecv;
                    bit_cnt_d  = 7'd1;
                    run_cnt_d  = 3'd1;
                    last_bit_d = 1'b0;
                    data_d     = '0;
                    crc_err_d  = 1'b0;
                end
            end
            StRecv: begin
                if (sampling_point) begin
                    if (run_cnt_q == 3'd5) begin
                        // Stuff bit: must be the complement of the run, then discarded.
                        if (rx == last_bit_q) begin
                            err_set  = 1'b1;
                            err_code = ErrStuff;
                        end else begin
                            run_cnt_d  = 3'd1;
                            last_bit_d = rx;
                        end
                    end else begin
                        bit_cnt_d  = bit_cnt_q + 7'd1;
                        run_cnt_d  = (rx == last_bit_q) ? run_cnt_q + 3'd1 : 3'd1;
                        last_bit_d = rx;
                        if (bit_cnt_q < crc_start) begin
                            crc_en = 1'b1;
                        end
                        if (bit_cnt_q <= 7'd11) begin
                            id_d = {id_q[CAN_ID_W-2:0], rx};
                        end else if (bit_cnt_q == 7'd12) begin
                            rtr_d = rx;
                        end else if (bit_cnt_q == 7'd13) begin
                            ide_d = rx;
                        end else if (bit_cnt_q >= 7'd15 && bit_cnt_q <= 7'd18) begin
                            dlc_d = {dlc_q[CAN_DLC_W-2:0], rx};
                        end else if (bit_cnt_q >= 7'd19 && bit_cnt_q < crc_start) begin
                            // First received data bit lands in tdata[63].
                            data_d[~data_idx] = rx;
                        end else if (bit_cnt_q >= crc_start && bit_cnt_q < crc_delim) begin
                            crc_rx_d = {crc_rx_q[CAN_CRC_W-2:0], rx};
                        end else if (bit_cnt_q == crc_delim) begin
                            if (!rx) begin
                                err_set  = 1'b1;
                                err_code = ErrForm;
                            end else begin
                                state_d       = StAck;
                                sub_cnt_d     = 3'd0;
                                crc_err_d     = (crc_val != crc_rx_q);
                                ack_pending_d = ACK_ENABLE && !can_sending &&
                                                (crc_val == crc_rx_q);
                            end
                        end
                    end
                end
            end
            StAck: begin
                if (sampling_point) begin
                    if (sub_cnt_q == 3'd0) begin
                        sub_cnt_d = 3'd1;
                    end else if (crc_err_q) begin
                        err_set  = 1'b1;
                        err_code = ErrCrc;
                    end else if (!rx) begin
                        err_set  = 1'b1;
                        err_code = ErrForm;
                    end else begin
                        state_d   = StEof;
                        sub_cnt_d = 3'd0;
                    end
                end
            end
            StEof: begin
                if (sampling_point) begin
                    if (!rx) begin
                        err_set  = 1'b1;
                        err_code = ErrForm;
                    end else if (sub_cnt_q == 3'(CAN_EOF_BITS - 1)) begin
                        state_d = StIdle;
                        load_d  = !rtr_q && !ide_q;
                    end else begin
                        sub_cnt_d = sub_cnt_q + 3'd1;
                    end
                end
            end
            StError: begin
                crc_clear = 1'b1;
                if (sampling_point) begin
                    if (!rx) begin
                        idle_cnt_d = '0;
                    end else if (idle_cnt_q == IdleW'(EOF_IDLE_BITS - 1)) begin
                        state_d    = StIdle;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (err_set) begin
            state_d       = StError;
            idle_cnt_d    = '0;
            ack_pending_d = 1'b0;
        end

        // Output register: a load in the handshake clock replaces the frame being taken.
        if (tvalid_q && stm_recv_data_out_tready) begin
            tvalid_d = 1'b0;
        end
        if (load_q) begin
            if (tvalid_q && !stm_recv_data_out_tready) begin
                ovf = 1'b1;
            end else begin
                tvalid_d = 1'b1;
                tdata_d  = data_q;
                tid_d    = id_q;
                tkeep_d  = dlc_to_keep(dlc_q);
            end
        end

        rx_error_d      = err_set | ovf;
        rx_error_code_d = err_set ? err_code : (ovf ? ErrOverflow : rx_error_code_q);
        can_receiving_d = (state_d == StRecv) || (state_d == StAck) || (state_d == StEof);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            bit_cnt_q       <= '0;
            run_cnt_q       <= '0;
            last_bit_q      <= 1'b1;
            sub_cnt_q       <= '0;
            idle_cnt_q      <= '0;
            id_q            <= '0;
            rtr_q           <= 1'b0;
            ide_q           <= 1'b0;
            dlc_q           <= '0;
            data_q          <= '0;
            crc_rx_q        <= '0;
            crc_err_q       <= 1'b0;
            ack_pending_q   <= 1'b0;
            txd_ack_q       <= 1'b1;
            load_q          <= 1'b0;
            rx_error_q      <= 1'b0;
            rx_error_code_q <= ErrStuff;
            can_receiving_q <= 1'b0;
            tdata_q         <= '0;
            tid_q           <= '0;
            tkeep_q         <= '0;
            tvalid_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            run_cnt_q       <= run_cnt_d;
            last_bit_q      <= last_bit_d;
            sub_cnt_q       <= sub_cnt_d;
            idle_cnt_q      <= idle_cnt_d;
            id_q            <= id_d;
            rtr_q           <= rtr_d;
            ide_q           <= ide_d;
            dlc_q           <= dlc_d;
            data_q          <= data_d;
            crc_rx_q        <= crc_rx_d;
            crc_err_q       <= crc_err_d;
            ack_pending_q   <= ack_pending_d;
            txd_ack_q       <= txd_ack_d;
            load_q          <= load_d;
            rx_error_q      <= rx_error_d;
            rx_error_code_q <= rx_error_code_d;
            can_receiving_q <= can_receiving_d;
            tdata_q         <= tdata_d;
            tid_q           <= tid_d;
            tkeep_q         <= tkeep_d;
            tvalid_q        <= tvalid_d;
        end
    end

    assign txd_ack                  = txd_ack_q;
    assign can_receiving            = can_receiving_q;
    assign rx_error                 = rx_error_q;
    assign rx_error_code            = rx_error_code_q;
    assign stm_recv_data_out_tdata  = tdata_q;
    assign stm_recv_data_out_tid    = tid_q;
    assign stm_recv_data_out_tkeep  = tkeep_q;
    assign stm_recv_data_out_tvalid = tvalid_q;

endmodule

// File: tb/tb_can_receiver.sv
// Directed bench for can_receiver: builds stuffed CAN frames bit by bit, scoreboards
// delivered frames, error pulses and ACK duration.
module tb_can_receiver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rxd_synced;
    logic        sync_point;
    logic        sampling_point;
    logic        can_sending;
    logic        txd_ack;
    logic        can_receiving;
    logic        rx_error;
    logic [1:0]  rx_error_code;
    logic [63:0] tdata;
    logic [10:0] tid;
    logic [7:0]  tkeep;
    logic        tvalid;
    logic        tready;

    always #5 clk = ~clk;

    can_receiver #(
        .EOF_IDLE_BITS (11),
        .ACK_ENABLE    (1'b1)
    ) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .rxd_synced               (rxd_synced),
        .sync_point               (sync_point),
        .sampling_point           (sampling_point),
        .can_sending              (can_sending),
        .txd_ack                  (txd_ack),
        .can_receiving            (can_receiving),
        .rx_error                 (rx_error),
        .rx_error_code            (rx_error_code),
        .stm_recv_data_out_tdata  (tdata),
        .stm_recv_data_out_tid    (tid),
        .stm_recv_data_out_tkeep  (tkeep),
        .stm_recv_data_out_tvalid (tvalid),
        .stm_recv_data_out_tready (tready)
    );

    typedef struct packed {
        logic [10:0] id;
        logic [63:0] data;
        logic [7:0]  keep;
    } frame_t;

    frame_t     exp_q[$];
    logic [1:0] err_q[$];
    bit         frame_bits[$];
    int         ack_low_cnt;
    int         n_vec;
    int         n_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: pop the expected frame when the DUT hands one over.
    always @(negedge clk) begin
        frame_t e;
        if (!txd_ack) ack_low_cnt++;
        if (rx_error) err_q.push_back(rx_error_code);
        if (tvalid && tready) begin
            n_vec++;
            assert (exp_q.size() > 0) else begin
                n_err++;
                $error("FAIL unexpected_frame: observed tid %0h, required no frame", tid);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_tid", 64'(tid), 64'(e.id));
                check("out_tdata", tdata, e.data);
                check("out_tkeep", 64'(tkeep), 64'(e.keep));
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: observed no finish, required finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic expect_frame(input logic [10:0] id, input logic [63:0] data,
                                input logic [7:0] keep);
        frame_t f;
        f.id   = id;
        f.data = data;
        f.keep = keep;
        exp_q.push_back(f);
    endtask

    task automatic build_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                               input logic [63:0] data, input int flip_crc_bit);
        bit          raw[$];
        logic [14:0] crc;
        int          nbytes;
        int          run;
        bit          last;
        bit          nxt;
        frame_bits.delete();
        raw.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
        raw.push_back(rtr);
        raw.push_back(1'b0);
        raw.push_back(1'b0);
        for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
        nbytes = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
        for (int i = 0; i < 8 * nbytes; i++) raw.push_back(data[63 - i]);
        crc = '0;
        foreach (raw[i]) begin
            nxt = raw[i] ^ crc[14];
            crc = {crc[13:0], 1'b0};
            if (nxt) crc = crc ^ 15'h4599;
        end
        if (flip_crc_bit >= 0) crc[flip_crc_bit] = ~crc[flip_crc_bit];
        for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
        run  = 0;
        last = 1'b0;
        foreach (raw[i]) begin
            frame_bits.push_back(raw[i]);
            if (run > 0 && raw[i] == last) run++;
            else run = 1;
            last = raw[i];
            if (run == 5) begin
                frame_bits.push_back(!last);
                last = !last;
                run  = 1;
            end
        end
        // CRC delimiter, ACK slot, ACK delimiter, 7 EOF bits.
        repeat (10) frame_bits.push_back(1'b1);
    endtask

    task automatic send_bit(input logic b);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #2;
            rxd_synced     = b;
            sync_point     = (i == 0);
            sampling_point = (i == 6);
        end
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic send_frame();
        foreach (frame_bits[i]) send_bit(frame_bits[i]);
    endtask

    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++) send_bit(frame_bits[i]);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_errs(input string tag, input int count, input logic [1:0] code);
        check({tag, "_err_count"}, 64'(err_q.size()), 64'(count));
        if (err_q.size() > 0) check({tag, "_err_code"}, 64'(err_q[0]), 64'(code));
        err_q.delete();
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        ack_low_cnt    = 0;
        rst_n          = 1'b0;
        rxd_synced     = 1'b1;
        sync_point     = 1'b0;
        sampling_point = 1'b0;
        can_sending    = 1'b0;
        tready         = 1'b1;
        wait_clks(3);

        // Reset state
        check("rst_txd_ack", 64'(txd_ack), 64'd1);
        check("rst_tvalid", 64'(tvalid), 64'd0);
        check("rst_tdata", tdata, 64'd0);
        check("rst_tid", 64'(tid), 64'd0);
        check("rst_tkeep", 64'(tkeep), 64'd0);
        check("rst_rx_error", 64'(rx_error), 64'd0);
        check("rst_can_receiving", 64'(can_receiving), 64'd0);
        rst_n = 1'b1;
        send_idle(12);

        // 1: ID 0x123, DLC 2, A5 5A
        ack_low_cnt = 0;
        expect_frame(11'h123, 64'hA55A_0000_0000_0000, 8'h03);
        build_frame(11'h123, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, -1);
        send_frame();
        send_idle(12);
        check("t1_ack_low_clks", 64'(ack_low_cnt), 64'd10);
        check("t1_delivered", 64'(exp_q.size()), 64'd0);
        check_errs("t1", 0, 2'd0);
        check("t1_can_receiving", 64'(can_receiving), 64'd0);

        // 2: ID 0, DLC 8, all-zero payload
        ack_low_cnt = 0;
        expect_frame(11'h000, 64'h0, 8'hFF);
        build_frame(11'h000, 1'b0, 4'd8, 64'h0, -1);
        send_frame();
        send_idle(12);
        check("t2_ack_low_clks", 64'(ack_low_cnt), 64'd10);
        check("t2_delivered", 64'(exp_q.size()), 64'd0);
        check_errs("t2", 0, 2'd0);

        // 3: CRC bit flipped, then a good frame after exactly 11 recessive bits
        ack_low_cnt = 0;
        build_frame(11'h123, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 3);
        send_frame();
        send_idle(4);
        check("t3_ack_low_clks", 64'(ack_low_cnt), 64'd0);
        check_errs("t3", 1, 2'd1);
        check("t3_tvalid", 64'(tvalid), 64'd0);
        expect_frame(11'h123, 64'hA55A_0000_0000_0000, 8'h03);
        build_frame(11'h123, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, -1);
        send_frame();
        send_idle(12);
        check("t3_recovered", 64'(exp_q.size()), 64'd0);
        check_errs("t3b", 0, 2'd0);

        // 4: six dominant bits (SOF + 5 ID bits)
        ack_low_cnt = 0;
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        check("t4_no_err_5th", 64'(err_q.size()), 64'd0);
        send_bit(1'b0);
        check_errs("t4", 1, 2'd0);
        check("t4_error_state", 64'(can_receiving), 64'd0);
        send_idle(11);
        check("t4_ack_low_clks", 64'(ack_low_cnt), 64'd0);

        // 5: back-to-back frames with tready low
        ack_low_cnt = 0;
        tready      = 1'b0;
        expect_frame(11'h055, 64'h3C00_0000_0000_0000, 8'h01);
        build_frame(11'h055, 1'b0, 4'd1, 64'h3C00_0000_0000_0000, -1);
        send_frame();
        send_idle(3);
        build_frame(11'h2AA, 1'b0, 4'd3, 64'h1122_3300_0000_0000, -1);
        send_frame();
        send_idle(3);
        check_errs("t5", 1, 2'd3);
        check("t5_tvalid_held", 64'(tvalid), 64'd1);
        check("t5_tid_held", 64'(tid), 64'h055);
        check("t5_tdata_held", tdata, 64'h3C00_0000_0000_0000);
        check("t5_ack_low_clks", 64'(ack_low_cnt), 64'd20);
        tready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) wait_clks(1);
        check("t5_drained", 64'(exp_q.size()), 64'd0);
        wait_clks(2);
        check("t5_tvalid_after", 64'(tvalid), 64'd0);

        // DLC 12 decodes as 8 bytes
        expect_frame(11'h456, 64'h0123_4567_89AB_CDEF, 8'hFF);
        build_frame(11'h456, 1'b0, 4'd12, 64'h0123_4567_89AB_CDEF, -1);
        send_frame();
        send_idle(12);
        check("dlc12_delivered", 64'(exp_q.size()), 64'd0);

        // RTR frame: acknowledged, not delivered
        ack_low_cnt = 0;
        build_frame(11'h321, 1'b1, 4'd4, 64'h0, -1);
        send_frame();
        send_idle(12);
        check("rtr_ack_low_clks", 64'(ack_low_cnt), 64'd10);
        check("rtr_tvalid", 64'(tvalid), 64'd0);
        check_errs("rtr", 0, 2'd0);

        // 6: reset in the middle of the data field
        build_frame(11'h0F0, 1'b0, 4'd4, 64'hDEAD_BEEF_0000_0000, -1);
        send_partial(30);
        check("t6_receiving", 64'(can_receiving), 64'd1);
        rst_n      = 1'b0;
        rxd_synced = 1'b1;
        wait_clks(2);
        check("t6_rst_txd_ack", 64'(txd_ack), 64'd1);
        check("t6_rst_tvalid", 64'(tvalid), 64'd0);
        check("t6_rst_receiving", 64'(can_receiving), 64'd0);
        rst_n = 1'b1;
        send_idle(2);
        ack_low_cnt = 0;
        expect_frame(11'h0F0, 64'hDEAD_BEEF_0000_0000, 8'h0F);
        send_frame();
        send_idle(12);
        check("t6_delivered", 64'(exp_q.size()), 64'd0);
        check("t6_ack_low_clks", 64'(ack_low_cnt), 64'd10);
        check_errs("t6", 0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
